// File: rtl/coherence_pkg.sv
// coherence_pkg: encodings shared by the MESIF coherence FSM and the bus-op sequencer.
package coherence_pkg;

  typedef enum logic [2:0] {
    BUS_OP_NONE       = 3'd0,
    BUS_OP_READ       = 3'd1,
    BUS_OP_WRITE      = 3'd2,
    BUS_OP_INVALIDATE = 3'd3,
    BUS_OP_RFO        = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNOOP_HIT   = 2'b00,
    SNOOP_HITM  = 2'b01,
    SNOOP_NOHIT = 2'b10
  } snoop_e;

  typedef enum logic [2:0] {
    MESIF_I = 3'd0,
    MESIF_S = 3'd1,
    MESIF_E = 3'd2,
    MESIF_F = 3'd3,
    MESIF_M = 3'd4
  } mesif_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ARB   = 2'd1,
    SEQ_SNOOP = 2'd2,
    SEQ_RESP  = 2'd3
  } seq_state_e;

  localparam logic [1:0] SNOOP_CODE_ILLEGAL = 2'b11;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_op_fifo.sv
// bus_op_fifo: synchronous FIFO holding {op, addr} requests; push when full and pop when empty are ignored.
module bus_op_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_op_sequencer.sv
// bus_op_sequencer: queues MESIF bus ops, arbitrates for the bus, collects snoop results.
// Optional statistics counters are built when BUS_OP_STATS_EN is defined.
module bus_op_sequencer #(
  parameter int ADDR_BITS     = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_op,
  output logic [1:0]           rsp_snoop,
  output logic                 rsp_timeout,
  output logic                 err,
  output logic                 bus_valid,
  output logic [2:0]           bus_op,
  output logic [ADDR_BITS-1:0] bus_addr,
  input  logic                 bus_grant,
  input  logic                 bus_snoop_valid,
  input  logic [1:0]           bus_snoop,
  input  logic [2:0]           stat_sel,
  output logic [15:0]          stat_data
);
  import coherence_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_BITS + 3;

  logic [ENT_W-1:0]     fifo_rdata;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 unused_fifo_full;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 illegal_push;
  logic [2:0]           head_op;
  logic [ADDR_BITS-1:0] head_addr;

  seq_state_e           state_q, state_n;
  logic [2:0]           op_q, op_n;
  logic [7:0]           snoop_cnt, snoop_cnt_n;
  logic                 bus_valid_n;
  logic [2:0]           bus_op_n;
  logic [ADDR_BITS-1:0] bus_addr_n;
  logic                 rsp_valid_n;
  logic [2:0]           rsp_op_n;
  logic [1:0]           rsp_snoop_n;
  logic                 rsp_timeout_n;
  logic                 snoop_err;
  logic                 granted;
  logic                 done_hitm;
  logic                 done_timeout;

  assign req_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign illegal_push = req_valid && req_ready && !is_legal_op(req_op);
  assign fifo_push    = req_valid && req_ready && is_legal_op(req_op);
  assign head_op      = fifo_rdata[ENT_W-1:ADDR_BITS];
  assign head_addr    = fifo_rdata[ADDR_BITS-1:0];

  bus_op_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({req_op, req_addr}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and next-output logic; the bus and response outputs are all registered below.
  always_comb begin
    state_n       = state_q;
    op_n          = op_q;
    snoop_cnt_n   = snoop_cnt;
    bus_valid_n   = bus_valid;
    bus_op_n      = bus_op;
    bus_addr_n    = bus_addr;
    rsp_valid_n   = 1'b0;
    rsp_op_n      = rsp_op;
    rsp_snoop_n   = rsp_snoop;
    rsp_timeout_n = rsp_timeout;
    fifo_pop      = 1'b0;
    snoop_err     = 1'b0;
    granted       = 1'b0;
    done_hitm     = 1'b0;
    done_timeout  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          op_n        = head_op;
          bus_valid_n = 1'b1;
          bus_op_n    = head_op;
          bus_addr_n  = head_addr;
          state_n     = SEQ_ARB;
        end
      end
      SEQ_ARB: begin
        if (bus_grant) begin
          granted     = 1'b1;
          bus_valid_n = 1'b0;
          bus_op_n    = '0;
          bus_addr_n  = '0;
          if (op_q == BUS_OP_WRITE) begin
            rsp_valid_n   = 1'b1;
            rsp_op_n      = op_q;
            rsp_snoop_n   = SNOOP_NOHIT;
            rsp_timeout_n = 1'b0;
            state_n       = SEQ_RESP;
          end else begin
            snoop_cnt_n = '0;
            state_n     = SEQ_SNOOP;
          end
        end
      end
      SEQ_SNOOP: begin
        snoop_cnt_n = snoop_cnt + 8'd1;
        if (bus_snoop_valid) begin
          rsp_valid_n   = 1'b1;
          rsp_op_n      = op_q;
          rsp_timeout_n = 1'b0;
          if (bus_snoop == SNOOP_CODE_ILLEGAL) begin
            snoop_err   = 1'b1;
            rsp_snoop_n = SNOOP_NOHIT;
          end else begin
            rsp_snoop_n = bus_snoop;
          end
          done_hitm = (bus_snoop == SNOOP_HITM);
          state_n   = SEQ_RESP;
        end else if (snoop_cnt == 8'(SNOOP_TIMEOUT - 1)) begin
          rsp_valid_n   = 1'b1;
          rsp_op_n      = op_q;
          rsp_snoop_n   = SNOOP_NOHIT;
          rsp_timeout_n = 1'b1;
          done_timeout  = 1'b1;
          state_n       = SEQ_RESP;
        end
      end
      SEQ_RESP: begin
        state_n = SEQ_IDLE;
      end
      default: begin
        state_n = SEQ_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight op without a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      op_q        <= '0;
      snoop_cnt   <= '0;
      bus_valid   <= 1'b0;
      bus_op      <= '0;
      bus_addr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
      rsp_snoop   <= SNOOP_NOHIT;
      rsp_timeout <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      snoop_cnt   <= snoop_cnt_n;
      bus_valid   <= bus_valid_n;
      bus_op      <= bus_op_n;
      bus_addr    <= bus_addr_n;
      rsp_valid   <= rsp_valid_n;
      rsp_op      <= rsp_op_n;
      rsp_snoop   <= rsp_snoop_n;
      rsp_timeout <= rsp_timeout_n;
      err         <= illegal_push | snoop_err;
    end
  end

`ifdef BUS_OP_STATS_EN
  logic [15:0] cnt_read, cnt_write, cnt_inval, cnt_rfo, cnt_hitm, cnt_timeout;

  // Ops are counted when granted; HITM and timeouts when the response is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_read    <= '0;
      cnt_write   <= '0;
      cnt_inval   <= '0;
      cnt_rfo     <= '0;
      cnt_hitm    <= '0;
      cnt_timeout <= '0;
    end else begin
      if (granted && op_q == BUS_OP_READ)       cnt_read  <= sat_inc(cnt_read);
      if (granted && op_q == BUS_OP_WRITE)      cnt_write <= sat_inc(cnt_write);
      if (granted && op_q == BUS_OP_INVALIDATE) cnt_inval <= sat_inc(cnt_inval);
      if (granted && op_q == BUS_OP_RFO)        cnt_rfo   <= sat_inc(cnt_rfo);
      if (done_hitm)    cnt_hitm    <= sat_inc(cnt_hitm);
      if (done_timeout) cnt_timeout <= sat_inc(cnt_timeout);
    end
  end

  // Registered statistics read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_data <= '0;
    end else begin
      case (stat_sel)
        3'd0:    stat_data <= cnt_read;
        3'd1:    stat_data <= cnt_write;
        3'd2:    stat_data <= cnt_inval;
        3'd3:    stat_data <= cnt_rfo;
        3'd4:    stat_data <= cnt_hitm;
        3'd5:    stat_data <= cnt_timeout;
        default: stat_data <= '0;
      endcase
    end
  end
`else
  logic [2:0] unused_stat_sel;
  logic       unused_stat_events;
  assign unused_stat_sel    = stat_sel;
  assign unused_stat_events = granted | done_hitm | done_timeout;
  assign stat_data          = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_op_sequencer.sv
// tb_bus_op_sequencer: scenario tasks plus randomized batches checked against a transaction-level model.
module tb_bus_op_sequencer;

  localparam int ADDR_BITS     = 32;
  localparam int FIFO_DEPTH    = 4;
  localparam int SNOOP_TIMEOUT = 8;
`ifdef BUS_OP_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 rsp_valid;
  logic [2:0]           rsp_op;
  logic [1:0]           rsp_snoop;
  logic                 rsp_timeout;
  logic                 err;
  logic                 bus_valid;
  logic [2:0]           bus_op;
  logic [ADDR_BITS-1:0] bus_addr;
  logic                 bus_grant;
  logic                 bus_snoop_valid;
  logic [1:0]           bus_snoop;
  logic [2:0]           stat_sel;
  logic [15:0]          stat_data;

  bus_op_sequencer #(
    .ADDR_BITS     (ADDR_BITS),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .SNOOP_TIMEOUT (SNOOP_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .rsp_valid       (rsp_valid),
    .rsp_op          (rsp_op),
    .rsp_snoop       (rsp_snoop),
    .rsp_timeout     (rsp_timeout),
    .err             (err),
    .bus_valid       (bus_valid),
    .bus_op          (bus_op),
    .bus_addr        (bus_addr),
    .bus_grant       (bus_grant),
    .bus_snoop_valid (bus_snoop_valid),
    .bus_snoop       (bus_snoop),
    .stat_sel        (stat_sel),
    .stat_data       (stat_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_wait = 0;
  int   stat_model[6];

  // Expected completion for one op given when (in SNOOP cycles) and what the snoopers answer.
  function automatic void predict(input logic [2:0] op, input int d, input logic [1:0] code,
                                  output int idx, output logic [1:0] sn, output logic to,
                                  output logic er);
    if (op == 3'd2) begin
      idx = 0; sn = 2'b10; to = 1'b0; er = 1'b0;
    end else if (d < SNOOP_TIMEOUT) begin
      idx = d + 1;
      sn  = (code == 2'b11) ? 2'b10 : code;
      to  = 1'b0;
      er  = (code == 2'b11);
    end else begin
      idx = SNOOP_TIMEOUT; sn = 2'b10; to = 1'b1; er = 1'b0;
    end
  endfunction

  task automatic clear_stat_model();
    for (int i = 0; i < 6; i++) stat_model[i] = 0;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] addr);
    logic legal;
    req_t e;
    legal     = (op >= 3'd1) && (op <= 3'd4);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL push_ready: got %b expected 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (legal) begin
      e.op = op; e.addr = addr;
      exp_q.push_back(e);
    end
    n_checks++;
    if (err !== !legal) begin
      n_fail++;
      $display("[TB] FAIL push_err op=%0d: got %b expected %b", op, err, !legal);
    end
  endtask

  // Drives one queued op through grant and snoop and checks bus and completion timing.
  task automatic run_op(input int gdel, input int d, input logic [1:0] code);
    req_t       e;
    int         idx;
    logic [1:0] sn;
    logic       to;
    logic       er;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL run_op_queue: got 0 queued ops expected at least 1");
      return;
    end
    e = exp_q.pop_front();
    last_wait = 0;
    while (bus_valid !== 1'b1 && last_wait < 20) begin
      @(negedge clk);
      last_wait++;
    end
    n_checks++;
    if (bus_valid !== 1'b1 || bus_op !== e.op || bus_addr !== e.addr) begin
      n_fail++;
      $display("[TB] FAIL bus_issue: got valid=%b op=%0d addr=%h expected valid=1 op=%0d addr=%h",
               bus_valid, bus_op, bus_addr, e.op, e.addr);
    end
    for (int i = 0; i < gdel; i++) begin
      bus_snoop_valid = 1'($urandom_range(0, 1));
      bus_snoop       = 2'($urandom_range(0, 3));
      @(negedge clk);
      n_checks++;
      if (bus_valid !== 1'b1 || bus_op !== e.op || bus_addr !== e.addr || rsp_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bus_hold: got valid=%b op=%0d addr=%h rsp=%b err=%b expected 1 %0d %h 0 0",
                 bus_valid, bus_op, bus_addr, rsp_valid, err, e.op, e.addr);
      end
    end
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    n_checks++;
    if (bus_valid !== 1'b0 || bus_op !== 3'd0 || bus_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL bus_release: got valid=%b op=%0d addr=%h expected 0 0 0", bus_valid, bus_op, bus_addr);
    end
    predict(e.op, d, code, idx, sn, to, er);
    stat_model[e.op - 1]++;
    if (e.op != 3'd2 && sn == 2'b01) stat_model[4]++;
    if (to) stat_model[5]++;
    for (int i = 0; i <= idx + 1; i++) begin
      if (i > 0) @(negedge clk);
      bus_snoop_valid = 1'b0;
      bus_snoop       = 2'b00;
      n_checks++;
      if (rsp_valid !== (i == idx)) begin
        n_fail++;
        $display("[TB] FAIL rsp_valid cycle %0d: got %b expected %b", i, rsp_valid, (i == idx));
      end
      if (i == idx) begin
        n_checks++;
        if (rsp_op !== e.op || rsp_snoop !== sn || rsp_timeout !== to) begin
          n_fail++;
          $display("[TB] FAIL rsp_fields: got op=%0d snoop=%b timeout=%b expected op=%0d snoop=%b timeout=%b",
                   rsp_op, rsp_snoop, rsp_timeout, e.op, sn, to);
        end
      end
      n_checks++;
      if (err !== (er && i == idx)) begin
        n_fail++;
        $display("[TB] FAIL snoop_err cycle %0d: got %b expected %b", i, err, (er && i == idx));
      end
      if (i == d && i < idx) begin
        bus_snoop_valid = 1'b1;
        bus_snoop       = code;
      end else if (i == idx) begin
        bus_snoop_valid = 1'b1;
        bus_snoop       = 2'b11;
      end
    end
    bus_snoop_valid = 1'b0;
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_valid !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL idle: got bus_valid=%b rsp_valid=%b err=%b ready=%b expected 0 0 0 1",
                 bus_valid, rsp_valid, err, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got ready=%b rsp_valid=%b err=%b expected 1 0 0", req_ready, rsp_valid, err);
    end
    n_checks++;
    if (rsp_op !== 3'd0 || rsp_snoop !== 2'b10 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_rsp: got op=%0d snoop=%b timeout=%b expected 0 10 0", rsp_op, rsp_snoop, rsp_timeout);
    end
    n_checks++;
    if (bus_valid !== 1'b0 || bus_op !== 3'd0 || bus_addr !== '0 || stat_data !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_bus: got valid=%b op=%0d addr=%h stat=%h expected 0 0 0 0",
               bus_valid, bus_op, bus_addr, stat_data);
    end
    exp_q.delete();
    clear_stat_model();
  endtask

  task automatic test_read();
    bus_grant = 1'b1;
    push(3'd1, 32'h0000_1000);
    bus_grant = 1'b0;
    run_op(0, 1, 2'b01);
    n_checks++;
    if (last_wait !== 1) begin
      n_fail++;
      $display("[TB] FAIL read_issue_latency: got %0d expected 1", last_wait);
    end
  endtask

  task automatic test_write();
    push(3'd2, 32'h0000_2040);
    run_op(3, 0, 2'b00);
    push(3'd2, 32'h0000_2080);
    run_op(0, 0, 2'b00);
    n_checks++;
    if (last_wait !== 1) begin
      n_fail++;
      $display("[TB] FAIL write_issue_latency: got %0d expected 1", last_wait);
    end
  endtask

  task automatic test_timeout();
    push(3'd4, 32'h0000_6000);
    run_op(0, 20, 2'b00);
    push(3'd3, 32'h0000_6040);
    run_op(1, SNOOP_TIMEOUT - 1, 2'b00);
    push(3'd1, 32'h0000_6080);
    run_op(0, 0, 2'b10);
  endtask

  task automatic test_illegal();
    push(3'd7, 32'h0000_5000);
    push(3'd0, 32'h0000_5040);
    push(3'd5, 32'h0000_5080);
    check_idle(3);
    push(3'd1, 32'h0000_5100);
    run_op(0, 2, 2'b11);
  endtask

  task automatic test_back_to_back();
    req_t e;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_op    = 3'((k % 4) + 1);
      req_addr  = 32'h0000_3000 + 32'(k * 64);
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready push %0d: got %b expected 1", k, req_ready);
      end
      @(negedge clk);
      e.op = req_op; e.addr = req_addr;
      exp_q.push_back(e);
    end
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_full: got ready=%b expected 0", req_ready);
    end
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_addr  = 32'hDEAD_0000;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_push_when_full: got ready=%b err=%b expected 0 0", req_ready, err);
    end
    for (int k = 0; k < 5; k++)
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 2'($urandom_range(0, 2)));
    bus_grant = 1'b1;
    check_idle(4);
    bus_grant = 1'b0;
  endtask

  task automatic test_random();
    int         n;
    int         q;
    logic [2:0] op;
    for (int b = 0; b < 10; b++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          op = 3'($urandom_range(0, 3));
          if (op != 3'd0) op = op + 3'd4;
          push(op, $urandom);
        end
        push(3'($urandom_range(1, 4)), $urandom);
      end
      q = exp_q.size();
      for (int k = 0; k < q; k++)
        run_op(int'($urandom_range(0, 4)), int'($urandom_range(0, 10)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_stats();
    int exp_val;
    for (int s = 0; s < 8; s++) begin
      stat_sel = 3'(s);
      @(negedge clk);
      exp_val = (STATS_EN && s < 6) ? stat_model[s] : 0;
      if (exp_val > 65535) exp_val = 65535;
      n_checks++;
      if (stat_data !== 16'(exp_val)) begin
        n_fail++;
        $display("[TB] FAIL stat_sel=%0d: got %0d expected %0d", s, stat_data, exp_val);
      end
    end
  endtask

  task automatic test_reset_mid();
    stat_sel = 3'd0;
    push(3'd1, 32'h0000_4000);
    push(3'd2, 32'h0000_4040);
    push(3'd4, 32'h0000_4080);
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clear_stat_model();
    n_checks++;
    if (rsp_valid !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1 || stat_data !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got rsp_valid=%b bus_valid=%b ready=%b stat=%h expected 0 0 1 0",
               rsp_valid, bus_valid, req_ready, stat_data);
    end
    bus_grant       = 1'b1;
    bus_snoop_valid = 1'b1;
    bus_snoop       = 2'b01;
    check_idle(4);
    bus_grant       = 1'b0;
    bus_snoop_valid = 1'b0;
    n_checks++;
    if (stat_data !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_stat: got %h expected 0", stat_data);
    end
  endtask

  initial begin
    rst             = 1'b1;
    req_valid       = 1'b0;
    req_op          = 3'd0;
    req_addr        = '0;
    bus_grant       = 1'b0;
    bus_snoop_valid = 1'b0;
    bus_snoop       = 2'b00;
    stat_sel        = 3'd0;
    clear_stat_model();
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_random();
    test_stats();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
